// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller: opcode
// constants, control-field encodings, the FSM state enum and the packed
// control word handed from the output decoder to the top.
package mc_ctrl_pkg;

   localparam int OP_WIDTH    = 6;
   localparam int STATE_WIDTH = 4;

   // Opcodes of the supported ISA subset
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // ALU operation requests consumed by the ALU control block
   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_XOR   = 3'b011;
   localparam logic [2:0] ALU_SLT   = 3'b100;

   // PC source mux
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // ALU operand B mux
   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   // Register file destination mux
   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;

   // Controller states; TRAP is only reachable when the illegal-op trap is built in
   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      R_WB      = 4'd7,
      EXEC_I    = 4'd8,
      I_WB      = 4'd9,
      BRANCH    = 4'd10,
      JUMP      = 4'd11,
      JAL       = 4'd12,
      TRAP      = 4'd13
   } state_t;

   // Full control word driven towards the datapath
   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       iOrD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       memToReg;
      logic       pcToReg;
      logic [1:0] regDst;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic       extMode;
      logic [2:0] aluOp;
      logic [1:0] pcSource;
   } ctrl_t;

   // I-type arithmetic needs {extMode, aluOp}; xori is the only zero-extending one
   function automatic logic [3:0] iTypeAluCtl(input logic [5:0] opCode);
      logic [3:0] ctl;
      ctl = {1'b1, ALU_ADD};
      case (opCode)
         OP_XORI: ctl = {1'b0, ALU_XOR};
         OP_SLTI: ctl = {1'b1, ALU_SLT};
         default: ctl = {1'b1, ALU_ADD};
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-word decoder for the multi-cycle controller.
// The word depends only on the current state and the opcode latched in
// DECODE; the single exception is FETCH, where the IR and PC loads wait
// for the memory to report the instruction word is ready.
module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  state_t     i_state,
   input  logic [5:0] i_op,
   input  logic       i_mem_ready,
   output ctrl_t      o_ctrl
);

   logic [3:0] w_iCtl;

   assign w_iCtl = iTypeAluCtl(i_op);

   // Per-state control word, everything not named for a state stays 0
   always_comb begin
      o_ctrl = '0;
      case (i_state)
         FETCH: begin
            o_ctrl.memRead  = 1'b1;
            o_ctrl.aluSrcB  = SRCB_FOUR;
            o_ctrl.aluOp    = ALU_ADD;
            o_ctrl.pcSource = PCSRC_ALU;
            o_ctrl.irWrite  = i_mem_ready;
            o_ctrl.pcWrite  = i_mem_ready;
         end
         DECODE: begin
            o_ctrl.aluSrcB = SRCB_IMMSH2;
            o_ctrl.extMode = 1'b1;
            o_ctrl.aluOp   = ALU_ADD;
         end
         MEM_ADDR: begin
            o_ctrl.aluSrcA = 1'b1;
            o_ctrl.aluSrcB = SRCB_IMM;
            o_ctrl.extMode = 1'b1;
            o_ctrl.aluOp   = ALU_ADD;
         end
         MEM_READ: begin
            o_ctrl.memRead = 1'b1;
            o_ctrl.iOrD    = 1'b1;
         end
         MEM_WB: begin
            o_ctrl.regWrite = 1'b1;
            o_ctrl.memToReg = 1'b1;
            o_ctrl.regDst   = REGDST_RT;
         end
         MEM_WRITE: begin
            o_ctrl.memWrite = 1'b1;
            o_ctrl.iOrD     = 1'b1;
         end
         EXEC_R: begin
            o_ctrl.aluSrcA = 1'b1;
            o_ctrl.aluSrcB = SRCB_RT;
            o_ctrl.aluOp   = ALU_FUNCT;
         end
         R_WB: begin
            o_ctrl.regWrite = 1'b1;
            o_ctrl.regDst   = REGDST_RD;
         end
         EXEC_I: begin
            o_ctrl.aluSrcA = 1'b1;
            o_ctrl.aluSrcB = SRCB_IMM;
            o_ctrl.extMode = w_iCtl[3];
            o_ctrl.aluOp   = w_iCtl[2:0];
         end
         I_WB: begin
            o_ctrl.regWrite = 1'b1;
            o_ctrl.regDst   = REGDST_RT;
            o_ctrl.extMode  = w_iCtl[3];
            o_ctrl.aluOp    = w_iCtl[2:0];
         end
         BRANCH: begin
            o_ctrl.aluSrcA     = 1'b1;
            o_ctrl.aluSrcB     = SRCB_RT;
            o_ctrl.aluOp       = ALU_SUB;
            o_ctrl.pcWriteCond = 1'b1;
            o_ctrl.pcSource    = PCSRC_ALUOUT;
         end
         JUMP: begin
            o_ctrl.pcWrite  = 1'b1;
            o_ctrl.pcSource = PCSRC_JUMP;
         end
         JAL: begin
            o_ctrl.pcWrite  = 1'b1;
            o_ctrl.pcSource = PCSRC_JUMP;
            o_ctrl.regWrite = 1'b1;
            o_ctrl.regDst   = REGDST_RA;
            o_ctrl.pcToReg  = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore main controller for the multi-cycle MIPS datapath. Sequences
// fetch/decode/execute/memory/writeback and stalls on mem_ready.
// Optional build macro ILLEGAL_OP_TRAP_EN: adds output illegal_op and a
// TRAP state that holds until reset; without it an unknown opcode is a
// two-cycle NOP.
module multi_cycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int STATE_W = 4
)
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [OP_W-1:0]    op,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic               pc_to_reg,
   output logic [1:0]         reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               ext_mode,
   output logic [2:0]         alu_op,
   output logic [1:0]         pc_source,
`ifdef ILLEGAL_OP_TRAP_EN
   output logic               illegal_op,
`endif
   output logic [STATE_W-1:0] state
);

   state_t     r_state;
   state_t     w_nextState;
   logic [5:0] r_op;
   ctrl_t      w_decCtrl;
   ctrl_t      w_ctrl;
   logic       w_unusedZero;

   // The datapath gates pc_write_cond with zero itself
   assign w_unusedZero = zero;

   // State register; reset always lands in FETCH
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Opcode latch so EXEC_I/I_WB and MEM_ADDR see a stable instruction class
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_op <= '0;
      end else if (r_state == DECODE) begin
         r_op <= op;
      end
   end

   // Next-state logic; stray encodings recover to FETCH
   always_comb begin
      w_nextState = FETCH;
      case (r_state)
         FETCH:     w_nextState = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LW, OP_SW:              w_nextState = MEM_ADDR;
               OP_RTYPE:                  w_nextState = EXEC_R;
               OP_ADDI, OP_XORI, OP_SLTI: w_nextState = EXEC_I;
               OP_BEQ:                    w_nextState = BRANCH;
               OP_J:                      w_nextState = JUMP;
               OP_JAL:                    w_nextState = JAL;
`ifdef ILLEGAL_OP_TRAP_EN
               default:                   w_nextState = TRAP;
`else
               default:                   w_nextState = FETCH;
`endif
            endcase
         end
         MEM_ADDR:  w_nextState = (r_op == OP_SW) ? MEM_WRITE : MEM_READ;
         MEM_READ:  w_nextState = mem_ready ? MEM_WB : MEM_READ;
         MEM_WB:    w_nextState = FETCH;
         MEM_WRITE: w_nextState = mem_ready ? FETCH : MEM_WRITE;
         EXEC_R:    w_nextState = R_WB;
         R_WB:      w_nextState = FETCH;
         EXEC_I:    w_nextState = I_WB;
         I_WB:      w_nextState = FETCH;
         BRANCH:    w_nextState = FETCH;
         JUMP:      w_nextState = FETCH;
         JAL:       w_nextState = FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
         TRAP:      w_nextState = TRAP;
`endif
         default:   w_nextState = FETCH;
      endcase
   end

   mc_ctrl_outdec u_outdec (
      .i_state     (r_state),
      .i_op        (r_op),
      .i_mem_ready (mem_ready),
      .o_ctrl      (w_decCtrl)
   );

   // Every output is forced low while reset is held, not just after the edge
   assign w_ctrl = reset_n ? w_decCtrl : '0;

   assign pc_write      = w_ctrl.pcWrite;
   assign pc_write_cond = w_ctrl.pcWriteCond;
   assign i_or_d        = w_ctrl.iOrD;
   assign mem_read      = w_ctrl.memRead;
   assign mem_write     = w_ctrl.memWrite;
   assign ir_write      = w_ctrl.irWrite;
   assign mem_to_reg    = w_ctrl.memToReg;
   assign pc_to_reg     = w_ctrl.pcToReg;
   assign reg_dst       = w_ctrl.regDst;
   assign reg_write     = w_ctrl.regWrite;
   assign alu_src_a     = w_ctrl.aluSrcA;
   assign alu_src_b     = w_ctrl.aluSrcB;
   assign ext_mode      = w_ctrl.extMode;
   assign alu_op        = w_ctrl.aluOp;
   assign pc_source     = w_ctrl.pcSource;
   assign state         = STATE_W'(r_state);

`ifdef ILLEGAL_OP_TRAP_EN
   assign illegal_op = reset_n && (r_state == TRAP);
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed testbench for multi_cycle_control. Each step drives op and
// mem_ready on the falling edge, queues the expected state and control
// word, then pops and compares them shortly afterwards.
module tb_multi_cycle_control;
   import mc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, pc_to_reg, reg_write, alu_src_a, ext_mode;
   logic [1:0] reg_dst, alu_src_b, pc_source;
   logic [2:0] alu_op;
   logic [3:0] state;
   logic       illegalObs;
`ifdef ILLEGAL_OP_TRAP_EN
   logic       illegal_op;
   assign illegalObs = illegal_op;
`else
   assign illegalObs = 1'b0;
`endif

   typedef struct {
      string      tag;
      logic [3:0] st;
      logic [19:0] word;
      logic       ill;
   } exp_t;

   exp_t sbQueue[$];
   int   assertCount = 0;
   int   failCount   = 0;

   logic [19:0] dutWord;
   assign dutWord = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
                     i_or_d, mem_to_reg, pc_to_reg, reg_dst, alu_src_a, alu_src_b,
                     ext_mode, alu_op, pc_source};

   multi_cycle_control dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .op            (op),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mem_to_reg    (mem_to_reg),
      .pc_to_reg     (pc_to_reg),
      .reg_dst       (reg_dst),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .ext_mode      (ext_mode),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
`ifdef ILLEGAL_OP_TRAP_EN
      .illegal_op    (illegal_op),
`endif
      .state         (state)
   );

   always #5 clk = ~clk;

   // Reference control word per state, written straight from the controller table
   function automatic logic [19:0] specWord(input state_t st, input logic [5:0] opV,
                                            input logic mrdy);
      logic pw, pwc, irw, rw, mr, mw, iod, m2r, p2r, asa, ext;
      logic [1:0] rd, asb, pcs;
      logic [2:0] aop;
      {pw, pwc, irw, rw, mr, mw, iod, m2r, p2r, asa, ext} = '0;
      rd = 2'b00; asb = 2'b00; pcs = 2'b00; aop = 3'b000;
      case (st)
         FETCH:     begin mr = 1'b1; asb = 2'b01; irw = mrdy; pw = mrdy; end
         DECODE:    begin asb = 2'b11; ext = 1'b1; end
         MEM_ADDR:  begin asa = 1'b1; asb = 2'b10; ext = 1'b1; end
         MEM_READ:  begin mr = 1'b1; iod = 1'b1; end
         MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
         MEM_WRITE: begin mw = 1'b1; iod = 1'b1; end
         EXEC_R:    begin asa = 1'b1; aop = 3'b010; end
         R_WB:      begin rw = 1'b1; rd = 2'b01; end
         EXEC_I, I_WB: begin
            if (st == EXEC_I) begin asa = 1'b1; asb = 2'b10; end
            else              begin rw = 1'b1; end
            if (opV == 6'b001110)      begin aop = 3'b011; ext = 1'b0; end
            else if (opV == 6'b001010) begin aop = 3'b100; ext = 1'b1; end
            else                       begin aop = 3'b000; ext = 1'b1; end
         end
         BRANCH:    begin asa = 1'b1; aop = 3'b001; pwc = 1'b1; pcs = 2'b01; end
         JUMP:      begin pw = 1'b1; pcs = 2'b10; end
         JAL:       begin pw = 1'b1; pcs = 2'b10; rw = 1'b1; rd = 2'b10; p2r = 1'b1; end
         default:   ;
      endcase
      return {pw, pwc, irw, rw, mr, mw, iod, m2r, p2r, rd, asa, asb, ext, aop, pcs};
   endfunction

   // Pop the oldest expectation and compare it with what the DUT shows now
   task automatic checkOutput();
      exp_t e;
      e = sbQueue.pop_front();
      assertCount++;
      assert (state === e.st) else begin
         failCount++;
         $error("FAIL %s state: observed %0d expected %0d", e.tag, state, e.st);
      end
      assertCount++;
      assert (dutWord === e.word) else begin
         failCount++;
         $error("FAIL %s ctrl: observed %05h expected %05h", e.tag, dutWord, e.word);
      end
      assertCount++;
      assert (illegalObs === e.ill) else begin
         failCount++;
         $error("FAIL %s illegal_op: observed %b expected %b", e.tag, illegalObs, e.ill);
      end
   endtask

   // One clock step: drive on the falling edge, queue the expectation, check
   task automatic applyStimulus(input string tag, input logic [5:0] opV,
                                input logic mrV, input state_t expSt);
      @(negedge clk);
      op        = opV;
      mem_ready = mrV;
      zero      = 1'($urandom_range(0, 1));
      sbQueue.push_back('{tag, 4'(expSt), specWord(expSt, opV, mrV), expSt == TRAP});
      #1;
      checkOutput();
   endtask

   // Pull reset mid-cycle, expect immediate FETCH with everything low
   task automatic asyncResetCheck(input string tag);
      #3;
      reset_n = 1'b0;
      sbQueue.push_back('{tag, 4'(FETCH), 20'h0, 1'b0});
      #1;
      checkOutput();
      @(negedge clk);
      sbQueue.push_back('{{tag, "_held"}, 4'(FETCH), 20'h0, 1'b0});
      #1;
      checkOutput();
   endtask

   // Release reset on a falling edge and expect a stalled FETCH
   task automatic releaseReset(input string tag);
      @(negedge clk);
      reset_n   = 1'b1;
      mem_ready = 1'b0;
      sbQueue.push_back('{tag, 4'(FETCH), specWord(FETCH, op, 1'b0), 1'b0});
      #1;
      checkOutput();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [5:0] iOps[3];
      reset_n   = 1'b0;
      op        = 6'b0;
      mem_ready = 1'b0;
      zero      = 1'b0;
      iOps[0]   = OP_XORI;
      iOps[1]   = OP_SLTI;
      iOps[2]   = OP_ADDI;
      $display("[TB] start");

      #2;
      sbQueue.push_back('{"reset_state", 4'(FETCH), 20'h0, 1'b0});
      checkOutput();
      releaseReset("reset_release");

      applyStimulus("lw_fetch",  OP_LW, 1'b1, FETCH);
      applyStimulus("lw_decode", OP_LW, 1'b1, DECODE);
      applyStimulus("lw_addr",   OP_LW, 1'b1, MEM_ADDR);
      applyStimulus("lw_read",   OP_LW, 1'b1, MEM_READ);
      applyStimulus("lw_wb",     OP_LW, 1'b1, MEM_WB);

      applyStimulus("sw_fetch",  OP_SW, 1'b1, FETCH);
      applyStimulus("sw_decode", OP_SW, 1'b1, DECODE);
      applyStimulus("sw_addr",   OP_SW, 1'b1, MEM_ADDR);
      for (int i = 0; i < 3; i++) applyStimulus("sw_stall", OP_SW, 1'b0, MEM_WRITE);
      applyStimulus("sw_write",  OP_SW, 1'b1, MEM_WRITE);

      applyStimulus("r_fetch_stall", OP_RTYPE, 1'b0, FETCH);
      applyStimulus("r_fetch",       OP_RTYPE, 1'b1, FETCH);
      applyStimulus("r_decode",      OP_RTYPE, 1'b1, DECODE);
      applyStimulus("r_exec",        OP_RTYPE, 1'b1, EXEC_R);
      applyStimulus("r_wb",          OP_RTYPE, 1'b1, R_WB);

      for (int k = 0; k < 3; k++) begin
         applyStimulus($sformatf("i%0d_fetch", k),  iOps[k], 1'b1, FETCH);
         applyStimulus($sformatf("i%0d_decode", k), iOps[k], 1'b1, DECODE);
         applyStimulus($sformatf("i%0d_exec", k),   iOps[k], 1'b1, EXEC_I);
         applyStimulus($sformatf("i%0d_wb", k),     iOps[k], 1'b1, I_WB);
      end

      applyStimulus("beq_fetch",  OP_BEQ, 1'b1, FETCH);
      applyStimulus("beq_decode", OP_BEQ, 1'b1, DECODE);
      applyStimulus("beq_branch", OP_BEQ, 1'b1, BRANCH);
      applyStimulus("jal_fetch",  OP_JAL, 1'b1, FETCH);
      applyStimulus("jal_decode", OP_JAL, 1'b1, DECODE);
      applyStimulus("jal_link",   OP_JAL, 1'b1, JAL);
      applyStimulus("j_fetch",    OP_J,   1'b1, FETCH);
      applyStimulus("j_decode",   OP_J,   1'b1, DECODE);
      applyStimulus("j_jump",     OP_J,   1'b1, JUMP);

      applyStimulus("abort_fetch",  OP_LW, 1'b1, FETCH);
      applyStimulus("abort_decode", OP_LW, 1'b1, DECODE);
      applyStimulus("abort_addr",   OP_LW, 1'b1, MEM_ADDR);
      applyStimulus("abort_read",   OP_LW, 1'b0, MEM_READ);
      asyncResetCheck("abort_reset");
      releaseReset("abort_release");

      applyStimulus("ill_fetch",  6'b111111, 1'b1, FETCH);
      applyStimulus("ill_decode", 6'b111111, 1'b1, DECODE);
`ifdef ILLEGAL_OP_TRAP_EN
      for (int i = 0; i < 3; i++) applyStimulus("ill_trap", 6'b111111, 1'b1, TRAP);
      asyncResetCheck("trap_reset");
      releaseReset("trap_release");
`else
      applyStimulus("ill_nop_fetch", 6'b111111, 1'b0, FETCH);
      applyStimulus("post_nop_fetch", OP_RTYPE, 1'b1, FETCH);
      applyStimulus("post_nop_decode", OP_RTYPE, 1'b1, DECODE);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
Moore-FSM main controller for the multi-cycle MIPS datapath. It covers the same ISA subset as the single-cycle decoder: lw, sw, j, jal, beq, addi, xori, slti and R-type. It sequences fetch, decode, execute, memory and writeback across cycles and stalls on a shared-memory ready handshake. It sits beside the datapath; the ALU control block consumes alu_op.

Parameters:
- OP_W, 6, opcode width
- STATE_W, 4, state register width; exported for debug

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- op  in  6  opcode field of the instruction register
- zero  in  1  ALU zero flag, used only in BRANCH state
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR
- pc_to_reg  out  1  writeback select PC (jal)
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
- ext_mode  out  1  1 = sign extend, 0 = zero extend
- alu_op  out  3  000 add, 001 sub, 010 funct, 011 xor, 100 slt
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  STATE_W  current state, for debug

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low, and forces state = FETCH. While reset_n = 0, all enables are 0 (pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write). All other outputs are 0 during reset.
- Output timing: outputs are a pure function of the state register (Moore); no output depends combinationally on op.
- Exceptions to the Moore rule: ir_write and pc_write in FETCH are ANDed with mem_ready. pc_write_cond is left to the datapath to AND with zero.
- Unlisted outputs in any state are 0.
- FETCH: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 000, pc_source = 00.
  - ir_write = pc_write = mem_ready.
  - Stay while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE: alu_src_a = 0, alu_src_b = 11, ext_mode = 1, alu_op = 000 (branch target precomputed). Next state by op:
  - 100011 / 101011 -> MEM_ADDR
  - 000000 -> EXEC_R
  - 001000 / 001110 / 001010 -> EXEC_I
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 000011 -> JAL
  - other -> see Optional Feature
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, ext_mode = 1, alu_op = 000. Next is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read = 1, i_or_d = 1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 00. Next FETCH.
- MEM_WRITE: mem_write = 1, i_or_d = 1. Hold until mem_ready, then FETCH. mem_write stays asserted for every stalled cycle.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 010. Next R_WB.
- R_WB: reg_write = 1, reg_dst = 01. Next FETCH.
- EXEC_I: alu_src_a = 1, alu_src_b = 10.
  - addi: alu_op 000, ext 1.
  - xori: alu_op 011, ext 0.
  - slti: alu_op 100, ext 1.
  - Opcode is held in an internal register captured in DECODE. Next I_WB.
- I_WB: reg_write = 1, reg_dst = 00, plus the same alu_op/ext as EXEC_I. Next FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 001, pc_write_cond = 1, pc_source = 01. Next FETCH.
- JUMP: pc_write = 1, pc_source = 10. Next FETCH.
- JAL: pc_write = 1, pc_source = 10, reg_write = 1, reg_dst = 10, pc_to_reg = 1. Next FETCH.
  - PC register still holds PC+4 during this cycle, so the link value is correct.
- Latency in cycles, with zero wait states: lw 5, sw 4, R 4, I-type 4, beq 3, j 3, jal 3. Each mem_ready = 0 cycle adds one.
- reset_n asserted mid-instruction: the instruction is aborted with no write. The first post-reset cycle is FETCH.
- Unused state encodings -> FETCH.

Optional Feature:
ILLEGAL_OP_TRAP_EN
- Defined: adds output illegal_op (1 bit) and state TRAP. An undefined opcode in DECODE goes to TRAP, which asserts illegal_op = 1 with all enables 0. The FSM stays in TRAP until reset. illegal_op resets to 0.
- Undefined: an undefined opcode in DECODE returns to FETCH as a 2-cycle NOP, with no register or memory write.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode constants: OP_LW, OP_SW, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_XORI, OP_SLTI, OP_RTYPE
  - ALU op encodings
  - pc_source, alu_src_b and reg_dst encodings
  - state enum typedef
- One natural sub-module: mc_ctrl_outdec, the combinational state(+latched op) -> control-word decoder. The FSM register and next-state logic stay in the top.

Test Plan:
- Reset: reset_n low mid-MEM_READ -> state = FETCH and all enables 0 immediately (asynchronous); after release, FETCH with mem_read = 1.
- lw (op 100011), mem_ready always 1 -> state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; reg_write = 1 with mem_to_reg = 1 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEM_WRITE -> mem_write held for 4 cycles; total 7 cycles; reg_write never asserted.
- xori (001110) -> in EXEC_I, alu_op = 011 and ext_mode = 0. slti (001010) -> alu_op = 100 and ext_mode = 1. Both write with reg_dst = 00.
- beq, then jal -> beq takes 3 cycles with pc_write_cond = 1 and pc_source = 01. jal asserts pc_write = 1, reg_dst = 10 and pc_to_reg = 1 in the same cycle.
- op 111111 -> with the macro: TRAP, illegal_op = 1 held. Without the macro: back to FETCH after 2 cycles with no writes.
